// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register-file write-back front end.
package regfile_pkg;

  localparam int DEF_RADDRWIDTH = 3;
  localparam int DEF_REGWIDTH   = 16;
  localparam int DEF_FIFO_DEPTH = 2;
  localparam int NREGS          = 2 ** DEF_RADDRWIDTH;

  typedef struct packed {
    logic [DEF_RADDRWIDTH-1:0] addr;
    logic [DEF_REGWIDTH-1:0]   data;
  } wb_req_t;

  // Width of an occupancy counter that must be able to hold the value depth itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding pending load write-backs; push/pop are ignored
// when full/empty respectively.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int  FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter type T          = wb_req_t
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  T                                 push_data,
  input  logic                             pop,
  output T                                 head,
  output logic [cnt_width(FIFO_DEPTH)-1:0] count,
  output logic                             full,
  output logic                             empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = cnt_width(FIFO_DEPTH);

  T                 r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full   = (r_count == CNT_W'(FIFO_DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, regardless of the order the always_ff blocks run in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the count and pointers decide what
  // is valid, and leaving the array out of reset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/regfile_wb.sv
// Write-back front end: arbitrates ALU and buffered load results onto the single
// register-file write port and tracks pending writes for RAW/WAW stalls.
module regfile_wb
  import regfile_pkg::*;
#(
  parameter int RADDRWIDTH = DEF_RADDRWIDTH,
  parameter int REGWIDTH   = DEF_REGWIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [RADDRWIDTH-1:0]    alu_waddr,
  input  logic [REGWIDTH-1:0]      alu_wdata,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [RADDRWIDTH-1:0]    mem_waddr,
  input  logic [REGWIDTH-1:0]      mem_wdata,
  input  logic                     issue_valid,
  input  logic [RADDRWIDTH-1:0]    issue_waddr,
  output logic                     issue_ready,
  output logic [2**RADDRWIDTH-1:0] busy,
  output logic                     we,
  output logic [RADDRWIDTH-1:0]    waddr,
  output logic [REGWIDTH-1:0]      wdata
);

  localparam int NUM_REGS = 2 ** RADDRWIDTH;
  localparam int CNT_W    = cnt_width(FIFO_DEPTH);

  typedef struct packed {
    logic [RADDRWIDTH-1:0] addr;
    logic [REGWIDTH-1:0]   data;
  } req_t;

  req_t                r_unused_guard;
  req_t                w_mem_req;
  req_t                w_head;
  req_t                w_sel;
  logic                w_sel_valid;
  logic                w_sel_write;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [CNT_W-1:0]    w_count;
  logic                w_has_space;
  logic                w_alu_fire;
  logic                w_mem_fire;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [NUM_REGS-1:0] w_busy_next;

  logic                  r_we;
  logic [RADDRWIDTH-1:0] r_waddr;
  logic [REGWIDTH-1:0]   r_wdata;
  logic [NUM_REGS-1:0]   r_busy;

  assign w_mem_req   = '{addr: mem_waddr, data: mem_wdata};
  assign w_has_space = (w_count < CNT_W'(FIFO_DEPTH));
  assign alu_ready   = !rst && w_has_space;
  assign mem_ready   = !rst && w_has_space;
  assign issue_ready = !rst && !r_busy[issue_waddr];
  assign w_alu_fire  = alu_valid && alu_ready;
  assign w_mem_fire  = mem_valid && mem_ready;

  wb_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .T          (req_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_mem_fire),
    .push_data (w_mem_req),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  // A full FIFO drains first so loads cannot be starved by a streaming ALU.
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel       = '0;
    w_pop       = 1'b0;
    if (w_full) begin
      w_pop       = 1'b1;
      w_sel_valid = 1'b1;
      w_sel       = w_head;
    end else if (w_alu_fire) begin
      w_sel_valid = 1'b1;
      w_sel       = '{addr: alu_waddr, data: alu_wdata};
    end else if (!w_empty) begin
      w_pop       = 1'b1;
      w_sel_valid = 1'b1;
      w_sel       = w_head;
    end
  end

  assign r_unused_guard = '0;
  assign w_sel_write    = w_sel_valid && (w_sel.addr != '0);

  // A set and a clear of the same register in one cycle leaves it busy.
  always_comb begin
    w_set_mask  = '0;
    w_clr_mask  = '0;
    if (issue_valid && issue_ready && (issue_waddr != '0))
      w_set_mask = NUM_REGS'(1) << issue_waddr;
    if (w_sel_valid)
      w_clr_mask = NUM_REGS'(1) << w_sel.addr;
    w_busy_next = ((r_busy & ~w_clr_mask) | w_set_mask) & ~NUM_REGS'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_busy  <= '0;
    end else begin
      r_we   <= w_sel_write;
      r_busy <= w_busy_next;
      if (w_sel_write) begin
        r_waddr <= w_sel.addr;
        r_wdata <= w_sel.data;
      end
    end
  end

  assign we    = r_we;
  assign waddr = r_waddr;
  assign wdata = r_wdata;
  assign busy  = r_busy;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench: stimulus queues expected write-backs, a negedge monitor checks
// every we pulse against the queue (address, data and cycle).
module tb_regfile_wb;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [2:0]  alu_waddr;
  logic [15:0] alu_wdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [2:0]  mem_waddr;
  logic [15:0] mem_wdata;
  logic        issue_valid;
  logic [2:0]  issue_waddr;
  logic        issue_ready;
  logic [7:0]  busy;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  regfile_wb #(
    .RADDRWIDTH (3),
    .REGWIDTH   (16),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_waddr   (alu_waddr),
    .alu_wdata   (alu_wdata),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .issue_valid (issue_valid),
    .issue_waddr (issue_waddr),
    .issue_ready (issue_ready),
    .busy        (busy),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wb_addr", 32'(waddr), 32'(e.addr));
        check("wb_data", 32'(wdata), 32'(e.data));
        check("wb_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid   = 1'b0;
    mem_valid   = 1'b0;
    issue_valid = 1'b0;
  endtask

  task automatic drive_alu(input logic [2:0] a, input logic [15:0] d);
    alu_valid = 1'b1;
    alu_waddr = a;
    alu_wdata = d;
  endtask

  task automatic drive_mem(input logic [2:0] a, input logic [15:0] d);
    mem_valid = 1'b1;
    mem_waddr = a;
    mem_wdata = d;
  endtask

  task automatic drive_issue(input logic [2:0] a);
    issue_valid = 1'b1;
    issue_waddr = a;
  endtask

  // Expected write-back 'delta' cycles after the current one.
  task automatic expect_wb(input logic [2:0] a, input logic [15:0] d, input int delta);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = cyc + delta;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    alu_waddr = '0; alu_wdata = '0; mem_waddr = '0; mem_wdata = '0; issue_waddr = '0;
    idle();
    tick();
    tick();
    check("rst_alu_ready", alu_ready, 0);
    check("rst_mem_ready", mem_ready, 0);
    check("rst_issue_ready", issue_ready, 0);
    rst = 1'b0;
    tick();
    check("post_rst_we", we, 0);
    check("post_rst_waddr", waddr, 0);
    check("post_rst_wdata", wdata, 0);
    check("post_rst_busy", busy, 8'h00);
    check("post_rst_alu_ready", alu_ready, 1);
    check("post_rst_mem_ready", mem_ready, 1);
    check("post_rst_issue_ready", issue_ready, 1);

    // Single ALU write: one-cycle latency.
    drive_alu(3'd3, 16'h1234);
    #1 check("alu_ready_basic", alu_ready, 1);
    expect_wb(3'd3, 16'h1234, 1);
    tick();
    idle();
    tick();

    // ALU and load in the same cycle: ALU first, load one cycle later.
    drive_alu(3'd2, 16'hAAAA);
    drive_mem(3'd5, 16'h5555);
    #1 check("both_alu_ready", alu_ready, 1);
    check("both_mem_ready", mem_ready, 1);
    expect_wb(3'd2, 16'hAAAA, 1);
    expect_wb(3'd5, 16'h5555, 2);
    tick();
    idle();
    tick();
    tick();
    check("fifo_drained_mem_ready", mem_ready, 1);

    // Fill the FIFO while the ALU streams, then watch it drain in order.
    drive_alu(3'd1, 16'h0101);
    drive_mem(3'd4, 16'h0001);
    expect_wb(3'd1, 16'h0101, 1);
    tick();
    drive_alu(3'd2, 16'h0102);
    drive_mem(3'd6, 16'h0002);
    #1 check("one_entry_alu_ready", alu_ready, 1);
    expect_wb(3'd2, 16'h0102, 1);
    tick();
    drive_alu(3'd3, 16'h0103);
    drive_mem(3'd7, 16'h0777);
    #1 check("full_alu_ready", alu_ready, 0);
    check("full_mem_ready", mem_ready, 0);
    expect_wb(3'd4, 16'h0001, 1);
    expect_wb(3'd6, 16'h0002, 2);
    tick();
    idle();
    #1 check("draining_alu_ready", alu_ready, 1);
    tick();
    tick();
    check("drained_alu_ready", alu_ready, 1);
    check("drained_mem_ready", mem_ready, 1);

    // Scoreboard: set, WAW stall, clear on selection, set-wins.
    drive_issue(3'd1);
    #1 check("issue1_ready", issue_ready, 1);
    tick();
    #1 check("busy_after_issue1", busy, 8'h02);
    check("waw_stall", issue_ready, 0);
    tick();
    idle();
    drive_alu(3'd1, 16'hBEEF);
    expect_wb(3'd1, 16'hBEEF, 1);
    #1 check("busy_before_clear", busy, 8'h02);
    tick();
    idle();
    #1 check("busy_cleared", busy, 8'h00);
    drive_alu(3'd1, 16'hCAFE);
    drive_issue(3'd1);
    #1 check("issue_same_cycle_ready", issue_ready, 1);
    expect_wb(3'd1, 16'hCAFE, 1);
    tick();
    idle();
    #1 check("set_wins", busy, 8'h02);
    drive_alu(3'd1, 16'h0F0F);
    expect_wb(3'd1, 16'h0F0F, 1);
    tick();
    idle();
    #1 check("busy_cleared_again", busy, 8'h00);

    // r0: results are consumed without a write; issue to r0 never stalls.
    drive_alu(3'd0, 16'hFFFF);
    #1 check("r0_alu_ready", alu_ready, 1);
    tick();
    idle();
    drive_mem(3'd0, 16'h1111);
    #1 check("r0_mem_ready", mem_ready, 1);
    tick();
    idle();
    drive_issue(3'd0);
    #1 check("r0_issue_ready", issue_ready, 1);
    tick();
    idle();
    tick();
    tick();
    check("r0_busy", busy, 8'h00);
    check("r0_no_we", we, 0);

    // Reset with two loads buffered and a register pending.
    drive_alu(3'd1, 16'h1001);
    drive_mem(3'd4, 16'h4004);
    drive_issue(3'd7);
    expect_wb(3'd1, 16'h1001, 1);
    tick();
    idle();
    drive_alu(3'd2, 16'h2002);
    drive_mem(3'd6, 16'h6006);
    expect_wb(3'd2, 16'h2002, 1);
    tick();
    idle();
    #1 check("pre_rst_busy", busy, 8'h80);
    check("pre_rst_full", mem_ready, 0);
    rst = 1'b1;
    #1 check("mid_rst_alu_ready", alu_ready, 0);
    check("mid_rst_mem_ready", mem_ready, 0);
    check("mid_rst_issue_ready", issue_ready, 0);
    tick();
    rst = 1'b0;
    #1 check("after_rst_we", we, 0);
    check("after_rst_busy", busy, 8'h00);
    check("after_rst_alu_ready", alu_ready, 1);
    check("after_rst_mem_ready", mem_ready, 1);
    repeat (5) tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Write-side front end for the 3-read/1-write register file, which has r0 hardwired to zero.
- Accepts results from two producers, the ALU and the load/memory unit, over valid/ready handshakes.
- Buffers load results in a small FIFO and arbitrates the single register-file write port.
- Keeps a per-register pending-write scoreboard so issue logic can stall on read-after-write (RAW) and write-after-write (WAW) hazards.

Parameters:
- RADDRWIDTH, 3, register address width; the register file has 2**RADDRWIDTH entries.
- REGWIDTH, 16, register data width.
- FIFO_DEPTH, 2, number of load-result entries; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid && alu_ready.
- alu_waddr  in  RADDRWIDTH  ALU destination register.
- alu_wdata  in  REGWIDTH  ALU result.
- mem_valid  in  1  load result valid.
- mem_ready  out  1  load result accepted into the FIFO when mem_valid && mem_ready.
- mem_waddr  in  RADDRWIDTH  load destination register.
- mem_wdata  in  REGWIDTH  load data.
- issue_valid  in  1  an instruction with destination issue_waddr is issuing.
- issue_waddr  in  RADDRWIDTH  destination of the issuing instruction.
- issue_ready  out  1  low when issue_waddr is already pending (WAW stall).
- busy  out  2**RADDRWIDTH  pending-write bit per register; bit 0 is always 0.
- we  out  1  register-file write enable.
- waddr  out  RADDRWIDTH  register-file write address.
- wdata  out  REGWIDTH  register-file write data.

Behaviour:
- Reset (rst high at a clk edge):
  - we=0, waddr=0, wdata=0, busy=0, FIFO empty (count=0, pointers=0).
  - alu_ready, mem_ready and issue_ready are forced to 0 combinationally while rst is high.
  - Any result in flight is discarded.
- Ready signals (combinational):
  - mem_ready = (count < FIFO_DEPTH).
  - alu_ready = (count < FIFO_DEPTH); when the FIFO is full it drains first, so loads cannot starve.
  - issue_ready = !busy[issue_waddr]; this is 1 for address 0.
- Arbitration, one write per cycle, priority order:
  - (1) FIFO full: pop the FIFO head.
  - (2) alu_valid && alu_ready: take the ALU result.
  - (3) FIFO non-empty: pop the FIFO head.
  - (4) Otherwise no write.
- Push and pop:
  - A load accepted in the same cycle it could be selected is pushed, never bypassed; minimum load latency is 2 cycles.
  - Push and pop in the same cycle leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Output register:
  - The selected entry is registered: we/waddr/wdata are valid in cycle N+1 for selection in cycle N.
  - ALU latency is 1 cycle from handshake to we.
  - The register file commits at the end of cycle N+1.
  - If nothing is selected, we=0 and waddr/wdata hold their previous values.
- Address 0: a result addressed to r0 is accepted and consumed but produces we=0 and never touches busy.
- Scoreboard, updated at the clk edge:
  - Set busy[issue_waddr] when issue_valid && issue_ready && issue_waddr != 0.
  - Clear busy[a] when a result for address a is selected for the output register, i.e. one edge before we is high.
  - Same address set and cleared in the same cycle: set wins.
  - A clear for a non-busy register is legal and leaves the bit 0.
- Data width: the write data is passed through unmodified; no sign or zero extension.
- Mid-operation reset: FIFO contents are lost and no we pulse follows. The producers and issue logic are reset by the same rst.

Decomposition:
- Shared package regfile_pkg contains:
  - Default RADDRWIDTH/REGWIDTH constants.
  - Typedef wb_req_t, a struct of addr and data.
  - Localparam NREGS = 2**RADDRWIDTH.
- One sub-module, wb_fifo:
  - Parameterised by FIFO_DEPTH; carries wb_req_t.
  - Ports: push, pop, head, count, full, empty.
  - Synchronous active-high reset.
- Arbiter, output register and scoreboard live in regfile_wb.

Test Plan:
- ALU write: alu_valid with addr 3, data 0x1234 in cycle 5 -> alu_ready=1; in cycle 6 we=1, waddr=3, wdata=0x1234; a register-file read of r3 returns 0x1234 from cycle 7.
- Load behind ALU: the same cycle carries alu addr 2/0xAAAA and mem addr 5/0x5555 -> ALU is written in cycle N+1, load in cycle N+2; count returns to 0.
- FIFO full, with FIFO_DEPTH=2:
  - Push loads 0x0001 and 0x0002 (addr 4, 6) while ALU results stream continuously.
  - With the FIFO full, alu_ready=0 and mem_ready=0.
  - The next two we pulses are loads, in order 4 then 6; alu_ready then returns to 1.
- Scoreboard:
  - issue addr 1 -> busy=0x02 next cycle; a second issue to addr 1 gets issue_ready=0.
  - An ALU result to addr 1 clears busy the cycle it is selected.
  - A new issue to addr 1 in that same cycle keeps busy[1]=1.
- r0: alu result addr 0, data 0xFFFF -> alu_ready=1, we never asserts, busy stays 0; issue addr 0 -> issue_ready=1, busy unchanged.
- Reset mid-flight: FIFO holds 2 loads, assert rst for 1 cycle -> readies are 0 during rst; afterwards we=0, busy=0, count=0, and no stale write appears.
